// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX resolution and perf signals of the branch predictor
interface branch_predictor_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] if_pc, pred_target, upd_pc, upd_target, upd_pred_target, redirect_pc;
  logic pred_hit, pred_taken, upd_valid, upd_is_taken, upd_pred_taken, mispredict;
  logic [31:0] perf_branches, perf_mispredicts;
  modport master (
    output if_pc, upd_valid, upd_pc, upd_is_taken, upd_target, upd_pred_taken, upd_pred_target,
    input pred_hit, pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispredicts
  );
  modport slave (
    input if_pc, upd_valid, upd_pc, upd_is_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc, perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, EX-stage training,
// mispredict/redirect generation and saturating perf counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic            r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic [31:0]     r_perf_br, r_perf_mis;
  logic [IDX_W-1:0] w_idx, w_upd_idx;
  logic [TAG_W-1:0] w_tag, w_upd_tag;
  logic            w_upd_hit;
  logic [1:0]      w_upd_ctr;
  assign w_idx     = bp.if_pc[IDX_W+1:2];
  assign w_tag     = bp.if_pc[XLEN-1:IDX_W+2];
  assign w_upd_idx = bp.upd_pc[IDX_W+1:2];
  assign w_upd_tag = bp.upd_pc[XLEN-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_ctr = r_ctr[w_upd_idx];
  assign bp.pred_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign bp.pred_taken  = bp.pred_hit && r_ctr[w_idx][1];
  assign bp.pred_target = bp.pred_taken ? r_target[w_idx] : bp.if_pc + XLEN'(4);
  assign bp.mispredict  = bp.upd_valid && ((bp.upd_is_taken != bp.upd_pred_taken) ||
                          (bp.upd_is_taken && (bp.upd_target != bp.upd_pred_target)));
  assign bp.redirect_pc = bp.upd_is_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
  assign bp.perf_branches    = r_perf_br;
  assign bp.perf_mispredicts = r_perf_mis;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_perf_br  <= '0;
      r_perf_mis <= '0;
    end else begin
      if (bp.upd_valid && w_upd_hit) begin
        r_ctr[w_upd_idx] <= bp.upd_is_taken ? ((w_upd_ctr == 2'b11) ? 2'b11 : w_upd_ctr + 2'b01)
                                            : ((w_upd_ctr == 2'b00) ? 2'b00 : w_upd_ctr - 2'b01);
        if (bp.upd_is_taken) r_target[w_upd_idx] <= bp.upd_target;
      end else if (bp.upd_valid && bp.upd_is_taken) begin
        // Miss on a taken branch replaces whatever lives at this index
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bp.upd_target;
        r_ctr[w_upd_idx]    <= 2'b10;
      end
      if (bp.upd_valid && (r_perf_br != '1)) r_perf_br <= r_perf_br + 32'd1;
      if (bp.mispredict && (r_perf_mis != '1)) r_perf_mis <= r_perf_mis + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenario tasks with hand-computed expectations for branch_predictor
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  branch_predictor_if #(.XLEN(32)) bp();
  branch_predictor #(.ENTRIES(16), .XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bp(bp));
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
    bp.upd_valid = v; bp.upd_pc = pc; bp.upd_is_taken = t; bp.upd_target = tgt;
    bp.upd_pred_taken = pt; bp.upd_pred_target = ptgt;
  endtask

  // one update: drive on negedge, check the combinational mispredict, then clock it in
  task automatic step(input string nm, input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptgt, input logic exp_mis, input logic [31:0] exp_rd);
    @(negedge clk);
    drive(1'b1, pc, t, tgt, pt, ptgt);
    #1;
    n_tests++; if (bp.mispredict !== exp_mis) begin n_fail++; $display("FAIL %s_mispredict got %0h exp %0h", nm, bp.mispredict, exp_mis); end
    if (exp_mis) begin
      n_tests++; if (bp.redirect_pc !== exp_rd) begin n_fail++; $display("FAIL %s_redirect got %h exp %h", nm, bp.redirect_pc, exp_rd); end
    end
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] tgt);
    bp.if_pc = pc;
    #1;
    n_tests++;
    if (bp.pred_hit !== hit || bp.pred_taken !== tk || bp.pred_target !== tgt) begin
      n_fail++;
      $display("FAIL %s got hit=%0h taken=%0h target=%h exp hit=%0h taken=%0h target=%h",
               nm, bp.pred_hit, bp.pred_taken, bp.pred_target, hit, tk, tgt);
    end
  endtask

  task automatic perf(input string nm, input logic [31:0] br, input logic [31:0] mis);
    n_tests++;
    if (bp.perf_branches !== br || bp.perf_mispredicts !== mis) begin
      n_fail++;
      $display("FAIL %s got br=%h mis=%h exp br=%h mis=%h", nm, bp.perf_branches, bp.perf_mispredicts, br, mis);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
    perf("reset_perf", 32'd0, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alloc;
    step("alloc", 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    look("alloc_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
    perf("alloc_perf", 32'd1, 32'd1);
  endtask

  task automatic test_counter;
    step("dec1", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    look("dec1_lookup", 32'h100, 1'b1, 1'b0, 32'h104);
    step("dec2", 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h0);
    step("dec3", 32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 32'h0);
    look("dec3_lookup", 32'h100, 1'b1, 1'b0, 32'h104);
    step("inc1", 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    look("inc1_lookup", 32'h100, 1'b1, 1'b0, 32'h104);
    step("inc2", 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b1, 32'h200);
    look("inc2_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
    step("inc3", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
    step("inc4", 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
    step("sat_dec", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    look("sat_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
    perf("counter_perf", 32'd9, 32'd5);
  endtask

  task automatic test_wrong_target;
    step("wrong_tgt", 32'h100, 1'b1, 32'h240, 1'b1, 32'h200, 1'b1, 32'h240);
    look("wrong_tgt_lookup", 32'h100, 1'b1, 1'b1, 32'h240);
    step("correct", 32'h100, 1'b1, 32'h240, 1'b1, 32'h240, 1'b0, 32'h0);
    perf("target_perf", 32'd11, 32'd6);
  endtask

  task automatic test_alias;
    step("alias", 32'h140, 1'b1, 32'h300, 1'b0, 32'h144, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
    step("miss_nt", 32'h180, 1'b0, 32'h0, 1'b0, 32'h184, 1'b0, 32'h0);
    look("miss_nt_keep", 32'h140, 1'b1, 1'b1, 32'h300);
    look("miss_nt_miss", 32'h180, 1'b0, 1'b0, 32'h184);
    perf("alias_perf", 32'd13, 32'd7);
  endtask

  task automatic test_wrap;
    @(negedge clk);
    drive(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h800, 1'b1, 32'h900);
    look("wrap_lookup", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    n_tests++; if (bp.mispredict !== 1'b0) begin n_fail++; $display("FAIL gated_mispredict got %0h exp 0", bp.mispredict); end
    n_tests++; if (bp.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_redirect got %h exp 0", bp.redirect_pc); end
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    perf("gated_perf", 32'd13, 32'd7);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 32'h104);
    look("same_cycle_old", 32'h100, 1'b0, 1'b0, 32'h104);
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("same_cycle_new", 32'h100, 1'b1, 1'b1, 32'h500);
    perf("b2b_perf", 32'd14, 32'd8);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b1, 32'h1C0, 1'b1, 32'h600, 1'b0, 32'h1C4);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    look("rst_mid_drop", 32'h1C0, 1'b0, 1'b0, 32'h1C4);
    look("rst_mid_clear", 32'h100, 1'b0, 1'b0, 32'h104);
    perf("rst_mid_perf", 32'd0, 32'd0);
  endtask

  task automatic test_perf_sat;
    @(negedge clk);
    force dut.r_perf_br = 32'hFFFF_FFFF;
    force dut.r_perf_mis = 32'hFFFF_FFFF;
    #1;
    release dut.r_perf_br;
    release dut.r_perf_mis;
    step("sat_upd", 32'h100, 1'b1, 32'h700, 1'b0, 32'h104, 1'b1, 32'h700);
    perf("perf_sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step("sat_upd2", 32'h100, 1'b1, 32'h700, 1'b0, 32'h104, 1'b1, 32'h700);
    perf("perf_sat2", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  initial begin
    bp.if_pc = 32'h100;
    test_reset();
    test_alloc();
    test_counter();
    test_wrong_target();
    test_alias();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_perf_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
